// File: rtl/hs_arb_pkg.sv
// rtl/hs_arb_pkg.sv - shared types and defaults for the hiscore RAM arbiter
//   hs_arb_state_t     : arbiter FSM state encoding
//   HS_ARB_AW          : default work-RAM address width
//   HS_ARB_DIM_CYCLES  : default paused-cycle threshold before the video dims
//   HS_ARB_SETTLE_W    : width of the settle down-counter (SETTLE_CYC is 1..15)
package hs_arb_pkg;

    localparam int          HS_ARB_AW         = 11;
    localparam logic [31:0] HS_ARB_DIM_CYCLES = 32'h11E1A300;
    localparam int          HS_ARB_SETTLE_W   = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_VBL = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_GRANT    = 3'd3,
        ST_RELEASE  = 3'd4
    } hs_arb_state_t;

endpackage

// File: rtl/pause_dim_timer.sv
// rtl/pause_dim_timer.sv - counts paused cycles and raises dim once the threshold is reached
//   clk    in  1  system clock
//   reset  in  1  asynchronous active-high reset
//   run    in  1  user pause is active; count while high, clear while low
//   dim    out 1  count has reached DIM_CYCLES
module pause_dim_timer
    import hs_arb_pkg::*;
#(
    parameter logic [31:0] DIM_CYCLES = HS_ARB_DIM_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic dim
);

    logic [31:0] count;

    // Saturates at the threshold so a very long pause never wraps back to undimmed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 32'd0;
        end else if (!run) begin
            count <= 32'd0;
        end else if (count < DIM_CYCLES) begin
            count <= count + 32'd1;
        end
    end

    assign dim = (count >= DIM_CYCLES);

endmodule

// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - shares the work RAM between the game core and the hiscore engine
// Optional feature macro: HS_ARB_DIM_EN (pause dim timer; dim tied low when undefined)
//   clk, reset                        in   clock, asynchronous active-high reset
//   vblank                            in   vertical blank, grant is only started on its rising edge
//   pause_btn, osd_pause              in   user pause button (level) and OSD pause request
//   hs_req                            in   hiscore engine wants the RAM, held until done
//   hs_addr/hs_wdata/hs_we            in   hiscore RAM port
//   core_addr/core_wdata/core_we      in   game-core RAM port
//   ram_addr/ram_wdata/ram_we         out  shared RAM port (combinational mux)
//   hs_ack                            out  hiscore engine owns the RAM
//   core_pause                        out  freeze the game core
//   dim                               out  dim the video after a long user pause
module hs_ram_arbiter
    import hs_arb_pkg::*;
#(
    parameter int          AW         = HS_ARB_AW,
    parameter int          SETTLE_CYC = 4,
    parameter logic [31:0] DIM_CYCLES = HS_ARB_DIM_CYCLES
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vblank,
    input  logic          pause_btn,
    input  logic          osd_pause,
    input  logic          hs_req,
    input  logic [AW-1:0] hs_addr,
    input  logic [7:0]    hs_wdata,
    input  logic          hs_we,
    input  logic [AW-1:0] core_addr,
    input  logic [7:0]    core_wdata,
    input  logic          core_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    output logic          hs_ack,
    output logic          core_pause,
    output logic          dim
);

    localparam logic [HS_ARB_SETTLE_W-1:0] SETTLE_LOAD = HS_ARB_SETTLE_W'(SETTLE_CYC - 1);

    // A zero dim threshold would dim the picture even when nothing is paused,
    // and the settle counter only holds values up to 15.
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle_cyc
        $error("hs_ram_arbiter: SETTLE_CYC must be in 1..15");
    end
    if (DIM_CYCLES == 32'd0) begin : g_bad_dim_cycles
        $error("hs_ram_arbiter: DIM_CYCLES must be non-zero");
    end

    hs_arb_state_t               state;
    hs_arb_state_t               next_state;
    logic [HS_ARB_SETTLE_W-1:0]  settle_cnt;
    logic                        vblank_q;
    logic                        pause_btn_q;
    logic                        pause_toggle;
    logic                        vblank_rise;
    logic                        hs_ack_next;
    logic                        core_pause_next;

    // A vblank that is already high when WAIT_VBL is entered is not a rising
    // edge, so the core always gets a full blanking period to reach a safe point.
    assign vblank_rise = vblank & ~vblank_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping hs_req before the grant abandons the request.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (hs_req) next_state = ST_WAIT_VBL;
            end
            ST_WAIT_VBL: begin
                if (!hs_req)          next_state = ST_IDLE;
                else if (vblank_rise) next_state = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!hs_req)                next_state = ST_IDLE;
                else if (settle_cnt == '0)  next_state = ST_GRANT;
            end
            ST_GRANT: begin
                if (!hs_req) next_state = ST_RELEASE;
            end
            ST_RELEASE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Output logic: RAM mux plus the next values of the registered outputs.
    // Writes are blocked in SETTLE and RELEASE so neither side can write while
    // ownership is changing hands.
    always_comb begin
        ram_addr  = core_addr;
        ram_wdata = core_wdata;
        ram_we    = 1'b0;
        case (state)
            ST_IDLE, ST_WAIT_VBL: begin
                ram_we = core_we;
            end
            ST_GRANT: begin
                ram_addr  = hs_addr;
                ram_wdata = hs_wdata;
                ram_we    = hs_we;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase

        // Built from next_state so hs_ack is already high in the first GRANT cycle.
        hs_ack_next     = (next_state == ST_GRANT);
        core_pause_next = pause_toggle | osd_pause |
                          ((state != ST_IDLE) && (state != ST_WAIT_VBL));
    end

    // Settle counter sits at its load value outside SETTLE, so it holds
    // SETTLE_CYC-1 on the first SETTLE cycle and reaches 0 on the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (state != ST_SETTLE) begin
            settle_cnt <= SETTLE_LOAD;
        end else if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 1'b1;
        end
    end

    // Registered outputs, input history and the pause toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hs_ack       <= 1'b0;
            core_pause   <= 1'b0;
            vblank_q     <= 1'b0;
            pause_btn_q  <= 1'b0;
            pause_toggle <= 1'b0;
        end else begin
            hs_ack      <= hs_ack_next;
            core_pause  <= core_pause_next;
            vblank_q    <= vblank;
            pause_btn_q <= pause_btn;
            if (pause_btn && !pause_btn_q) begin
                pause_toggle <= ~pause_toggle;
            end
        end
    end

`ifdef HS_ARB_DIM_EN
    pause_dim_timer #(
        .DIM_CYCLES (DIM_CYCLES)
    ) u_pause_dim_timer (
        .clk   (clk),
        .reset (reset),
        .run   (pause_toggle),
        .dim   (dim)
    );
`else
    assign dim = 1'b0;
`endif

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// tb/tb_hs_ram_arbiter.sv - scoreboard bench for hs_ram_arbiter
module tb_hs_ram_arbiter;

    localparam int          AW     = 11;
    localparam int          SETTLE = 4;
    localparam logic [31:0] DIMC   = 32'd100;
`ifdef HS_ARB_DIM_EN
    localparam bit DIM_ON = 1'b1;
`else
    localparam bit DIM_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          vblank = 1'b0, pause_btn = 1'b0, osd_pause = 1'b0, hs_req = 1'b0;
    logic [AW-1:0] hs_addr = '0, core_addr = '0;
    logic [7:0]    hs_wdata = '0, core_wdata = '0;
    logic          hs_we = 1'b0, core_we = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we, hs_ack, core_pause, dim;

    hs_ram_arbiter #(.AW(AW), .SETTLE_CYC(SETTLE), .DIM_CYCLES(DIMC)) dut (
        .clk(clk), .reset(reset), .vblank(vblank), .pause_btn(pause_btn),
        .osd_pause(osd_pause), .hs_req(hs_req),
        .hs_addr(hs_addr), .hs_wdata(hs_wdata), .hs_we(hs_we),
        .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .hs_ack(hs_ack), .core_pause(core_pause), .dim(dim)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Scoreboard of expected grant windows (absolute cycles).
    typedef struct { int g; int rel; } grant_t;
    grant_t sb[$];
    grant_t cur;
    bit     have_cur = 1'b0;

    // Timeline phase of the current cycle, set by stimulus:
    // 0 idle, 1 waiting for vblank, 2 settling, 3 granted, 4 releasing.
    int exp_phase = 0;
    bit mon_en = 1'b0;

    // Reference model of pause toggle / dim, one cycle of history.
    bit m_tog = 0, m_b1 = 0, m_b2 = 0, m_o1 = 0, m_busy1 = 0;
    int m_run = 0;
    bit tog_now, prev_ack = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_phase == 3) begin
                chk("ram_addr_hs", 32'(ram_addr), 32'(hs_addr));
                chk("ram_wdata_hs", 32'(ram_wdata), 32'(hs_wdata));
                chk("ram_we_hs", 32'(ram_we), 32'(hs_we));
            end else begin
                chk("ram_addr_core", 32'(ram_addr), 32'(core_addr));
                chk("ram_wdata_core", 32'(ram_wdata), 32'(core_wdata));
                chk("ram_we_core", 32'(ram_we), (exp_phase <= 1) ? 32'(core_we) : 32'd0);
            end
            chk("hs_ack_level", 32'(hs_ack), 32'(exp_phase == 3));

            if (hs_ack && !prev_ack) begin
                if (sb.size() == 0) begin
                    chk("ack_unexpected", 32'(hs_ack), 32'd0);
                end else begin
                    cur = sb.pop_front();
                    have_cur = 1'b1;
                    chk("ack_rise_cycle", 32'(cyc), 32'(cur.g));
                end
            end
            if (!hs_ack && prev_ack && have_cur) begin
                chk("ack_fall_cycle", 32'(cyc), 32'(cur.rel));
                have_cur = 1'b0;
            end

            chk("core_pause", 32'(core_pause), 32'(m_tog | m_o1 | m_busy1));
            m_run = m_tog ? m_run + 1 : 0;
            chk("dim", 32'(dim), 32'(DIM_ON && (m_run >= int'(DIMC))));

            tog_now = m_tog ^ (m_b1 & ~m_b2);
            m_tog   = tog_now;
            m_b2    = m_b1;
            m_b1    = pause_btn;
            m_o1    = osd_pause;
            m_busy1 = (exp_phase >= 2);
        end
        prev_ack = hs_ack;
    end

    // One stimulus cycle; btn < 0 lets the pause button wander randomly.
    task automatic drive(input logic req, input logic vb, input int ph, input int btn);
        @(posedge clk);
        #1;
        hs_req     = req;
        vblank     = vb;
        exp_phase  = ph;
        core_addr  = AW'($urandom);
        core_wdata = 8'($urandom);
        core_we    = 1'($urandom_range(0, 1));
        hs_addr    = AW'($urandom);
        hs_wdata   = 8'($urandom);
        hs_we      = 1'($urandom_range(0, 1));
        osd_pause  = ($urandom_range(0, 7) == 0);
        if (btn < 0) begin
            if ($urandom_range(0, 15) == 0) pause_btn = ~pause_btn;
        end else begin
            pause_btn = 1'(btn);
        end
    endtask

    // One hiscore request, laid out as a timeline relative to its first cycle.
    // pre: vblank already high when hs_req rises (from r-pre_lead until r+pre_len).
    // abort_off: -1 none, 0 random drop before grant, >0 drop at r+abort_off.
    task automatic run_txn(input int gap, input bit pre, input int pre_lead, input int pre_len,
                           input int low_len, input int abort_off, input int hold);
        int r, vstart, vfall, v, vend, g, d, a, t_end, base, ph;
        bit abort, rq, vb;
        r = gap;
        if (pre) begin
            vstart = r - pre_lead;
            vfall  = r + pre_len;
            v      = vfall + low_len;
        end else begin
            vstart = 0;
            vfall  = 0;
            v      = r + low_len;
        end
        vend  = v + 2;
        g     = v + SETTLE + 1;
        d     = g + hold;
        abort = (abort_off >= 0);
        a     = (abort_off == 0) ? r + $urandom_range(1, g - 1 - r) : r + abort_off;
        t_end = abort ? a + 1 : d + 2;
        if (vend > t_end) t_end = vend;
        base = cyc + 1;
        if (!abort) sb.push_back('{g: base + g, rel: base + d + 1});
        for (int t = 0; t <= t_end; t++) begin
            rq = (t >= r) && (abort ? (t < a) : (t < d));
            vb = (pre && t >= vstart && t < vfall) || (t >= v && t < vend);
            if (t <= r)                ph = 0;
            else if (abort && t > a)   ph = 0;
            else if (t <= v)           ph = 1;
            else if (t <= v + SETTLE)  ph = 2;
            else if (t <= d)           ph = 3;
            else if (t == d + 1)       ph = 4;
            else                       ph = 0;
            drive(rq, vb, ph, -1);
        end
    endtask

    int c2, got;

    initial begin
        core_addr = 11'h123;
        core_we   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hs_ack", 32'(hs_ack), 32'd0);
        chk("rst_core_pause", 32'(core_pause), 32'd0);
        chk("rst_dim", 32'(dim), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'h123);
        chk("rst_ram_we", 32'(ram_we), 32'd1);
        core_addr = '0;
        core_we   = 1'b0;
        #2;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed timelines
        run_txn(10, 0, 0, 0, 40, -1, 3);   // request at 10, vblank rise 40 cycles later
        run_txn(3, 1, 1, 2, 3, -1, 2);     // vblank already high when request arrives
        run_txn(3, 1, 0, 1, 2, -1, 0);     // vblank rises in the same cycle as the request
        run_txn(3, 0, 0, 0, 3, 5, 0);      // request dropped during settle
        run_txn(3, 0, 0, 0, 5, 2, 0);      // request dropped while waiting for vblank

        for (int i = 0; i < 60; i++) begin
            run_txn($urandom_range(2, 6), 1'($urandom_range(0, 1)), $urandom_range(0, 1),
                    $urandom_range(1, 3), $urandom_range(1, 4),
                    ($urandom_range(0, 3) == 0) ? 0 : -1, $urandom_range(0, 5));
        end

        // Long user pause: dim after DIMC paused cycles, cleared by the next press.
        repeat (3) drive(0, 0, 0, 0);
        if (m_tog) begin
            drive(0, 0, 0, 1);
            repeat (3) drive(0, 0, 0, 0);
        end
        drive(0, 0, 0, 1);
        repeat (110) drive(0, 0, 0, 0);
        @(negedge clk);
        chk("dim_after_long_pause", 32'(dim), 32'(DIM_ON));
        drive(0, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 0);
        @(negedge clk);
        chk("dim_after_unpause", 32'(dim), 32'd0);

        // Reset in the middle of a grant.
        mon_en = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        repeat (6) drive(1, 0, 0, 0);
        hs_addr   = 11'h3F0;
        hs_we     = 1'b1;
        core_addr = 11'h123;
        core_we   = 1'b1;
        @(negedge clk);
        chk("grant_hs_ack", 32'(hs_ack), 32'd1);
        chk("grant_ram_addr", 32'(ram_addr), 32'h3F0);
        chk("grant_ram_we", 32'(ram_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_hs_ack", 32'(hs_ack), 32'd0);
        chk("async_rst_ram_addr", 32'(ram_addr), 32'h123);
        chk("async_rst_ram_wdata", 32'(ram_wdata), 32'(core_wdata));
        chk("async_rst_ram_we", 32'(ram_we), 32'd1);
        chk("async_rst_core_pause", 32'(core_pause), 32'd0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 0);
        c2  = cyc;
        got = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (hs_ack) begin
                got = cyc;
                break;
            end
        end
        chk("regrant_cycle", 32'(got), 32'(c2 + SETTLE + 1));
        repeat (4) drive(0, 0, 0, 0);
        @(negedge clk);
        chk("regrant_release", 32'(hs_ack), 32'd0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hs_ram_arbiter.md
HS_RAM_ARBITER -- requirements
Module: hs_ram_arbiter

Interface
REQ-001 Parameter AW, 11, work-RAM address width.
REQ-002 Parameter SETTLE_CYC, 4, cycles the core is held paused before the hiscore port is granted (range 1..15).
REQ-003 Parameter DIM_CYCLES, 32'h11E1A300, paused cycles before dim asserts.
REQ-004 clk  in  1  system clock; the single clock for all logic.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 vblank  in  1  video vertical blank, synchronous to clk.
REQ-007 pause_btn  in  1  user pause button, level.
REQ-008 osd_pause  in  1  pause request while the OSD is open, level.
REQ-009 hs_req  in  1  hiscore engine requests the RAM, level, held until done.
REQ-010 hs_addr/hs_wdata/hs_we  in  AW/8/1  hiscore RAM port.
REQ-011 core_addr/core_wdata/core_we  in  AW/8/1  game-core RAM port.
REQ-012 ram_addr/ram_wdata/ram_we  out  AW/8/1  muxed shared RAM port.
REQ-013 hs_ack  out  1  hiscore owns the RAM.
REQ-014 core_pause  out  1  freezes the game core.
REQ-015 dim  out  1  dims the video after a long user pause.

Function
REQ-016 The FSM SHALL use states IDLE, WAIT_VBL, SETTLE, GRANT and RELEASE, registered on clk.
REQ-017 IDLE -> WAIT_VBL when hs_req=1, including a cycle in which vblank also rises.
REQ-018 WAIT_VBL -> SETTLE on a vblank rising edge (vblank=1 with the previous-cycle vblank=0); a vblank already high on entry is not accepted.
REQ-019 SETTLE loads a counter with SETTLE_CYC-1 on entry and moves to GRANT when the counter reaches 0 (exactly SETTLE_CYC cycles in SETTLE).
REQ-020 GRANT holds while hs_req=1 and moves to RELEASE when hs_req=0.
REQ-021 RELEASE lasts one cycle, then returns to IDLE.
REQ-022 hs_req=0 in WAIT_VBL or SETTLE aborts to IDLE with no grant; hs_ack stays 0.
REQ-023 hs_ack = (state==GRANT), registered, asserted the first GRANT cycle.
REQ-024 The mux SHALL be combinational (0 latency).
- ram_addr/ram_wdata: from hs_* in GRANT, otherwise from core_*.
- ram_we: hs_we in GRANT; core_we in IDLE and WAIT_VBL; 0 in SETTLE and RELEASE.
REQ-025 pause_toggle SHALL invert on each rising edge of pause_btn.
REQ-026 core_pause = pause_toggle | osd_pause | (state != IDLE && state != WAIT_VBL), registered.
REQ-027 The dim counter (32 bits) SHALL increment while pause_toggle=1, saturate at DIM_CYCLES, and clear to 0 when pause_toggle=0.
REQ-028 dim = (count >= DIM_CYCLES).
REQ-029 A pause_btn edge during GRANT SHALL toggle pause_toggle without affecting the FSM.

Reset
REQ-030 Asserting reset SHALL immediately force state=IDLE, with pause_toggle, counters, hs_ack, core_pause, dim and the vblank/pause_btn history registers all 0.
REQ-031 Reset asserted in GRANT SHALL drop hs_ack and return RAM ownership to the core asynchronously.

Configuration
REQ-032 Macro HS_ARB_DIM_EN:
- Defined: the dim counter and dim output are implemented per REQ-027/028.
- Undefined: no counter is synthesized and dim is tied to 0; all other behaviour is unchanged.

Structure
REQ-033 Package hs_arb_pkg SHALL hold the state enum typedef, the default AW constant and the default DIM_CYCLES constant.
REQ-034 The dim counter SHALL be the sub-module pause_dim_timer (inputs clk, reset, run; output dim), instantiated only under HS_ARB_DIM_EN.

Verification
REQ-035 hs_req=1 at cycle 10, vblank rising at cycle 50 -> SETTLE cycles 51-54, hs_ack=1 from cycle 55, core_pause=1 from cycle 52.
REQ-036 In GRANT, hs_addr=0x3F0, hs_we=1, core_we=1 -> ram_addr=0x3F0, ram_we=1 and the core write is suppressed; in IDLE, core_addr=0x123 -> ram_addr=0x123.
REQ-037 vblank already 1 when hs_req rises -> no grant until vblank falls and rises again.
REQ-038 hs_req dropped in SETTLE -> IDLE, hs_ack never asserts, core_pause=0 after one cycle.
REQ-039 With DIM_CYCLES=100 and HS_ARB_DIM_EN defined: pause_btn pulse -> dim=1 after 100 cycles; a second pulse -> dim=0 the next cycle. Without the macro, dim stays 0.
REQ-040 Reset pulse mid-GRANT -> hs_ack=0 and ram_* follow core_* immediately; hs_req still high -> the FSM re-arbitrates from IDLE.
